// File: rtl/pixel_scanner.sv
//------------------------------------------------------------------------------
// pixel_scanner : raster-order (x,y) coordinate source with valid/ready output,
//                 single-shot/continuous frames, inter-frame gap and abort.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_scanner #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAME_GAP     = 4,
    parameter int FC_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic                abort,
    input  logic                out_ready,
    output logic [31:0]         screen_x,
    output logic [31:0]         screen_y,
    output logic                coords_valid,
    output logic                sof,
    output logic                eol,
    output logic                eof,
    output logic                busy,
    output logic [FC_WIDTH-1:0] frame_count
);

    localparam int c_MAX_DIM  = (SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT;
    localparam int CW         = $clog2(c_MAX_DIM + 1);
    localparam int GW         = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int c_GAP_LOAD = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

    localparam logic [CW-1:0] c_X_MAX = CW'(SCREEN_WIDTH - 1);
    localparam logic [CW-1:0] c_Y_MAX = CW'(SCREEN_HEIGHT - 1);
    // Flags carried by the (0,0) beat; degenerate widths/heights make it eol/eof too
    localparam logic c_EOL0 = (SCREEN_WIDTH == 1);
    localparam logic c_EOF0 = (SCREEN_WIDTH == 1) && (SCREEN_HEIGHT == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [GW-1:0] r_gap;

    logic          w_x_last;
    logic          w_last;
    logic          w_xfer;
    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;

    assign w_x_last = (r_x == c_X_MAX);
    assign w_last   = w_x_last && (r_y == c_Y_MAX);
    assign w_xfer   = coords_valid && out_ready;
    assign w_nx     = w_x_last ? '0 : r_x + CW'(1);
    assign w_ny     = w_x_last ? r_y + CW'(1) : r_y;

    assign screen_x = {{(32-CW){1'b0}}, r_x};
    assign screen_y = {{(32-CW){1'b0}}, r_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_gap        <= '0;
            coords_valid <= 1'b0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            eof          <= 1'b0;
            busy         <= 1'b0;
            frame_count  <= '0;
        end else if (abort) begin
            // An eof transfer in the same cycle is deliberately not counted
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_gap        <= '0;
            coords_valid <= 1'b0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            eof          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_SCAN;
                        r_x          <= '0;
                        r_y          <= '0;
                        coords_valid <= 1'b1;
                        sof          <= 1'b1;
                        eol          <= c_EOL0;
                        eof          <= c_EOF0;
                        busy         <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            frame_count <= frame_count + FC_WIDTH'(1);
                            r_x         <= '0;
                            r_y         <= '0;
                            if (continuous && (FRAME_GAP == 0)) begin
                                sof <= 1'b1;
                                eol <= c_EOL0;
                                eof <= c_EOF0;
                            end else if (continuous) begin
                                r_state      <= S_GAP;
                                r_gap        <= GW'(c_GAP_LOAD);
                                coords_valid <= 1'b0;
                                sof          <= 1'b0;
                                eol          <= 1'b0;
                                eof          <= 1'b0;
                            end else begin
                                r_state      <= S_IDLE;
                                coords_valid <= 1'b0;
                                sof          <= 1'b0;
                                eol          <= 1'b0;
                                eof          <= 1'b0;
                                busy         <= 1'b0;
                            end
                        end else begin
                            r_x <= w_nx;
                            r_y <= w_ny;
                            sof <= 1'b0;
                            eol <= (w_nx == c_X_MAX);
                            eof <= (w_nx == c_X_MAX) && (w_ny == c_Y_MAX);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_state      <= S_SCAN;
                        coords_valid <= 1'b1;
                        sof          <= 1'b1;
                        eol          <= c_EOL0;
                        eof          <= c_EOF0;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    coords_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_scanner.sv
//------------------------------------------------------------------------------
// tb_pixel_scanner : directed self-checking bench for pixel_scanner
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pixel_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // A: 4x3, gap 4 ; B: 4x3, gap 0 ; C: 1x1, gap 0, 2-bit frame counter
    logic        start_a, cont_a, abort_a, ready_a;
    logic        start_b, cont_b, abort_b, ready_b;
    logic        start_c, cont_c, abort_c, ready_c;
    logic [31:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
    logic        v_a, sof_a, eol_a, eof_a, busy_a;
    logic        v_b, sof_b, eol_b, eof_b, busy_b;
    logic        v_c, sof_c, eol_c, eof_c, busy_c;
    logic [15:0] fc_a, fc_b;
    logic [1:0]  fc_c;

    pixel_scanner #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .FRAME_GAP(4), .FC_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .abort(abort_a),
        .out_ready(ready_a), .screen_x(sx_a), .screen_y(sy_a), .coords_valid(v_a),
        .sof(sof_a), .eol(eol_a), .eof(eof_a), .busy(busy_a), .frame_count(fc_a));

    pixel_scanner #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .FRAME_GAP(0), .FC_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .abort(abort_b),
        .out_ready(ready_b), .screen_x(sx_b), .screen_y(sy_b), .coords_valid(v_b),
        .sof(sof_b), .eol(eol_b), .eof(eof_b), .busy(busy_b), .frame_count(fc_b));

    pixel_scanner #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1), .FRAME_GAP(0), .FC_WIDTH(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .continuous(cont_c), .abort(abort_c),
        .out_ready(ready_c), .screen_x(sx_c), .screen_y(sy_c), .coords_valid(v_c),
        .sof(sof_c), .eol(eol_c), .eof(eof_c), .busy(busy_c), .frame_count(fc_c));

    logic [20:0] obs_a, obs_b, obs_c;
    assign obs_a = {v_a, busy_a, sof_a, eol_a, eof_a, sx_a[7:0], sy_a[7:0]};
    assign obs_b = {v_b, busy_b, sof_b, eol_b, eof_b, sx_b[7:0], sy_b[7:0]};
    assign obs_c = {v_c, busy_c, sof_c, eol_c, eof_c, sx_c[7:0], sy_c[7:0]};

    localparam logic [20:0] c_IDLE = 21'd0;
    localparam logic [20:0] c_GAP  = {1'b0, 1'b1, 19'd0};

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [20:0] exp_beat(input int i, input int w, input int h);
        return {1'b1, 1'b1, (i == 0), ((i % w) == w - 1), (i == w * h - 1),
                8'(i % w), 8'(i / w)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, cyc, gap;
        logic [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1;
        {start_a, cont_a, abort_a, ready_a} = '0;
        {start_b, cont_b, abort_b, ready_b} = '0;
        {start_c, cont_c, abort_c, ready_c} = '0;
        #12;
        chk("reset_a", obs_a, c_IDLE);
        chk("reset_fc_a", fc_a, 0);
        chk("reset_b", obs_b, c_IDLE);
        chk("reset_c", {obs_c, fc_c}, 0);
        tick();
        rst = 1'b0;
        tick();

        // single frame, always ready
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_beat%0d", i), obs_a, exp_beat(i, 4, 3));
            tick();
        end
        chk("t1_idle", obs_a, c_IDLE);
        chk("t1_fc", fc_a, 1);

        // backpressure: fixed 1,0,0,1 then random
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 12 && cyc < 200) begin
            ready_a = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
            chk($sformatf("t2_beat%0d", k), obs_a, exp_beat(k, 4, 3));
            tick();
            if (ready_a) k++;
            cyc++;
        end
        chk("t2_done", k, 12);
        ready_a = 1'b1;
        chk("t2_idle", obs_a, c_IDLE);
        chk("t2_fc", fc_a, 2);

        // continuous with 4-cycle gap, three frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_fc0", fc_a, 0);
        cont_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 12; i++) begin
                if (f == 2 && i == 11) cont_a = 1'b0;
                chk($sformatf("t3_f%0d_beat%0d", f, i), obs_a, exp_beat(i, 4, 3));
                tick();
            end
            if (f < 2) begin
                gap = 0;
                while (!v_a && gap < 20) begin
                    chk("t3_gap", obs_a, c_GAP);
                    gap++;
                    tick();
                end
                chk("t3_gaplen", gap, 4);
            end
        end
        chk("t3_idle", obs_a, c_IDLE);
        chk("t3_fc", fc_a, 3);

        // back-to-back continuous frames
        ready_b = 1'b1;
        cont_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 23) cont_b = 1'b0;
            chk($sformatf("t4_beat%0d", i), obs_b, exp_beat(i % 12, 4, 3));
            tick();
        end
        chk("t4_idle", obs_b, c_IDLE);
        chk("t4_fc", fc_b, 2);

        // abort at beat 5
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_beat5", obs_a, exp_beat(5, 4, 3));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t5_abort_idle", obs_a, c_IDLE);
        chk("t5_abort_fc", fc_a, 3);
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        {start_a, abort_a} = '0;
        chk("t5_start_abort", obs_a, c_IDLE);
        tick();
        chk("t5_still_idle", obs_a, c_IDLE);

        // abort coinciding with the eof transfer: frame not counted
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t5_restart", obs_a, exp_beat(0, 4, 3));
        for (int i = 0; i < 11; i++) tick();
        chk("t5_beat11", obs_a, exp_beat(11, 4, 3));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t5_eof_abort_idle", obs_a, c_IDLE);
        chk("t5_eof_abort_fc", fc_a, 3);

        // start pulsed mid-frame is ignored
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            start_a = (i == 3);
            chk($sformatf("t6_beat%0d", i), obs_a, exp_beat(i, 4, 3));
            tick();
        end
        start_a = 1'b0;
        chk("t6_idle", obs_a, c_IDLE);
        chk("t6_fc", fc_a, 4);

        // asynchronous reset mid-frame
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t6_beat7", obs_a, exp_beat(7, 4, 3));
        rst = 1'b1;
        #1;
        chk("t6_async_rst", {obs_a, fc_a}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_restart", obs_a, c_IDLE);

        // 1x1 frames, 2-bit counter wraps
        ready_c = 1'b1;
        cont_c = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t7_beat%0d", i), obs_c, exp_beat(0, 1, 1));
            if (i == 3) cont_c = 1'b0;
            tick();
            chk($sformatf("t7_fc%0d", i), fc_c, (i + 1) % 4);
        end
        chk("t7_idle", obs_c, c_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
